// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the synchronous data RAM controller.
// Optional clear engine is enabled with the SYNC_RAM_CLEAR_EN macro (see sync_ram_ctrl).
package sync_ram_pkg;

  // Clear-engine states: normal operation, or sweeping zeros through the array.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Merge one byte lane: take the new byte when its enable is set, else keep the old one.
  function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sync_ram_rsp_pipe.sv
// Response delay line for the RAM controller. The payload MSB is the valid strobe;
// the rest (data/error) only advances with a valid entry, so the output holds its
// last value while no response is moving. STAGES = 0 is a pure pass-through.
module sync_ram_rsp_pipe #(
  parameter int STAGES = 1,
  parameter int PW     = 34
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] data_i,
  output logic [PW-1:0] data_o
);

  genvar gi;

  generate
    if (STAGES == 0) begin : g_bypass
      assign data_o = data_i;
    end else begin : g_pipe
      for (gi = 0; gi < STAGES; gi++) begin : g_st
        logic [PW-1:0] stage_q;
        logic [PW-1:0] stage_d;

        if (gi == 0) begin : g_first
          assign stage_d = data_i;
        end else begin : g_rest
          assign stage_d = g_st[gi-1].stage_q;
        end

        // Valid always shifts; payload only moves with a valid entry; reset flushes.
        always_ff @(posedge clk) begin
          if (reset) begin
            stage_q <= '0;
          end else if (stage_d[PW-1]) begin
            stage_q <= stage_d;
          end else begin
            stage_q[PW-1] <= 1'b0;
          end
        end
      end
      assign data_o = g_st[STAGES-1].stage_q;
    end
  endgenerate

endmodule

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous data RAM with valid/ready requests and fixed-latency responses.
// Byte write enables, out-of-range error flagging, RD_LAT of 1 or 2.
// Define SYNC_RAM_CLEAR_EN to add a clear engine that zeroes the array after every reset.
module sync_ram_ctrl
  import sync_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic              accept;
  logic              in_range;
  logic [AW-1:0]     req_idx;

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              v1_q;
  logic              err1_q;
  logic              zero1_q;

  rsp_t              rsp_s1;
  rsp_t              rsp_out;

  // Upper address bits only decide range; the low bits index the array.
  assign in_range = (req_addr < ADDR_W'(DEPTH));
  assign req_idx  = req_addr[AW-1:0];
  assign accept   = req_valid & req_ready;

`ifdef SYNC_RAM_CLEAR_EN
  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // Clear sweep: one word per cycle, leave after writing the last index.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Reset always (re)starts the sweep from index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign req_ready = ~busy;
  assign wr_en     = busy | (accept & req_we & in_range);
  assign wr_idx    = busy ? ptr_q : req_idx;
  assign wr_be     = busy ? {NB{1'b1}} : req_be;
  assign wr_data   = busy ? {DATA_W{1'b0}} : req_wdata;
`else
  assign busy      = 1'b0;
  assign req_ready = 1'b1;
  assign wr_en     = accept & req_we & in_range;
  assign wr_idx    = req_idx;
  assign wr_be     = req_be;
  assign wr_data   = req_wdata;
`endif

  // Array write port with per-byte enables; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered array read, captured only on an accepted read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (accept && !req_we) begin
      ram_q <= mem[req_idx];
    end
  end

  // First response stage: strobe every cycle, data/error qualifiers only on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      err1_q  <= 1'b0;
      zero1_q <= 1'b1;
    end else begin
      v1_q <= accept;
      if (accept) begin
        err1_q  <= ~in_range;
        zero1_q <= req_we | ~in_range;
      end
    end
  end

  assign rsp_s1.valid = v1_q;
  assign rsp_s1.rdata = zero1_q ? {DATA_W{1'b0}} : ram_q;
  assign rsp_s1.err   = err1_q;

  sync_ram_rsp_pipe #(
    .STAGES (RD_LAT - 1),
    .PW     ($bits(rsp_t))
  ) u_rsp_pipe (
    .clk    (clk),
    .reset  (reset),
    .data_i (rsp_s1),
    .data_o (rsp_out)
  );

  assign rsp_valid = rsp_out.valid;
  assign rsp_rdata = rsp_out.rdata;
  assign rsp_err   = rsp_out.err;

endmodule
